// File: rtl/gatilho_contador_if.sv
// Handshake bundle for gatilho_contador: shared tick, per-channel arm/count in, pulse/status out.
// The abort lane only exists when GATILHO_ABORT_EN is defined.
interface gatilho_contador_if #(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 8
);
    logic                        tick;
    logic [CHANNELS-1:0]         start;
    logic [CHANNELS*COUNT_W-1:0] count_load;
`ifdef GATILHO_ABORT_EN
    logic [CHANNELS-1:0]         abort;
`endif
    logic [CHANNELS-1:0]         pulse_out;
    logic [CHANNELS-1:0]         done;
    logic [CHANNELS-1:0]         finished;
    logic [CHANNELS-1:0]         busy;

`ifdef GATILHO_ABORT_EN
    modport master (
        output tick, start, count_load, abort,
        input  pulse_out, done, finished, busy
    );
    modport slave (
        input  tick, start, count_load, abort,
        output pulse_out, done, finished, busy
    );
`else
    modport master (
        output tick, start, count_load,
        input  pulse_out, done, finished, busy
    );
    modport slave (
        input  tick, start, count_load,
        output pulse_out, done, finished, busy
    );
`endif
endinterface

// File: rtl/gatilho_contador.sv
// Multi-channel pulse-count trigger: each armed channel forwards exactly N ticks, then flags done.
// Latency: start -> RUN next cycle; tick -> pulse_out one cycle later (registered enables, no gating).
// No backpressure: start is ignored while RUN; optional abort lane via GATILHO_ABORT_EN.
module gatilho_contador #(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    gatilho_contador_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [CHANNELS-1:0] pulse_w;
    logic [CHANNELS-1:0] done_w;
    logic [CHANNELS-1:0] fin_w;
    logic [CHANNELS-1:0] busy_w;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            state_t               state;
            logic [COUNT_W-1:0]   remaining;
            logic [COUNT_W-1:0]   load_val;
            logic                 pulse_q;
            logic                 done_q;
            logic                 fin_q;
            logic                 busy_q;

            assign load_val = bus.count_load[i*COUNT_W +: COUNT_W];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    pulse_q   <= 1'b0;
                    done_q    <= 1'b0;
                    fin_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end else begin
                    pulse_q <= 1'b0;
                    done_q  <= 1'b0;
                    unique case (state)
                        ST_IDLE, ST_DONE: begin
                            // Abort is deliberately not consulted here, so start always wins.
                            if (bus.start[i]) begin
                                remaining <= load_val;
                                if (load_val != '0) begin
                                    state  <= ST_RUN;
                                    busy_q <= 1'b1;
                                    fin_q  <= 1'b0;
                                end else begin
                                    state  <= ST_DONE;
                                    done_q <= 1'b1;
                                    fin_q  <= 1'b1;
                                    busy_q <= 1'b0;
                                end
                            end
                        end
                        ST_RUN: begin
`ifdef GATILHO_ABORT_EN
                            if (bus.abort[i]) begin
                                state     <= ST_IDLE;
                                remaining <= '0;
                                busy_q    <= 1'b0;
                                fin_q     <= 1'b0;
                            end else
`endif
                            if (bus.tick && remaining != '0) begin
                                pulse_q   <= 1'b1;
                                remaining <= remaining - COUNT_W'(1);
                                if (remaining == COUNT_W'(1)) begin
                                    state  <= ST_DONE;
                                    done_q <= 1'b1;
                                    fin_q  <= 1'b1;
                                    busy_q <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            state     <= ST_IDLE;
                            remaining <= '0;
                            fin_q     <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    endcase
                end
            end

            assign pulse_w[i] = pulse_q;
            assign done_w[i]  = done_q;
            assign fin_w[i]   = fin_q;
            assign busy_w[i]  = busy_q;
        end
    endgenerate

    assign bus.pulse_out = pulse_w;
    assign bus.done      = done_w;
    assign bus.finished  = fin_w;
    assign bus.busy      = busy_w;

endmodule

// File: doc/gatilho_contador.md
# gatilho_contador

Parametrised multi-channel pulse-count trigger for the irrigation controller. Each channel is armed with a count N. It then forwards exactly N cycles of the shared `tick` strobe to its output, stops, and flags completion. This replaces the fixed two-edge gated-clock trigger. Outputs are synchronous, registered enables, so no clock gating is used. Valve and pump drivers consume these enables in the `clk` domain.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent trigger channels (≥1).
- `COUNT_W`, 8: width of each channel's pulse count (≥1); max N = 2^COUNT_W−1.

Ports:
- `clk`, in, 1: single system clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset).
- `tick`, in, 1: shared strobe, one `clk` cycle wide per event; sampled each cycle.
- `start`, in, CHANNELS: per-channel arm request, level sampled each cycle.
- `count_load`, in, CHANNELS*COUNT_W: channel i count is bits [i*COUNT_W +: COUNT_W].
- `pulse_out`, out, CHANNELS: registered gated copy of `tick` per channel.
- `done`, out, CHANNELS: one-cycle completion pulse per channel.
- `finished`, out, CHANNELS: level, high while channel is in DONE.
- `busy`, out, CHANNELS: level, high while channel is in RUN.
- `abort`, in, CHANNELS: present only with `GATILHO_ABORT_EN`.

## Operation
- Each channel holds an independent FSM with states IDLE, RUN and DONE, plus a COUNT_W-bit `remaining` register.
- Reset (asynchronous, `reset`=0):
  - all channels go to IDLE with `remaining`=0;
  - `pulse_out`, `done`, `finished` and `busy` are all 0.
- In IDLE or DONE, when `start[i]`=1:
  - load `remaining` from the channel's `count_load` slice;
  - if the loaded value ≠0, go to RUN;
  - if the loaded value =0, go to DONE and assert `done[i]` for one cycle; no pulses are issued.
- In RUN, when `tick`=1:
  - assert `pulse_out[i]` for one cycle and decrement `remaining`;
  - if `remaining` was 1, also go to DONE and assert `done[i]` on the same edge.
- In RUN, `start[i]` is ignored and no reload occurs. `count_load` is don't-care outside the cycle in which a start is accepted.
- In RUN, when `tick`=0, the channel holds its state.
- DONE holds until the next accepted `start[i]`, so a channel can be re-armed from DONE with no pass through IDLE.
- Channels never interact. Any combination of channels may start, pulse or finish in the same cycle.
- `remaining` never wraps; no decrement occurs at 0.

## Timing
- `start[i]` sampled at edge k: RUN from k+1. The earliest `tick` that counts is the one sampled at edge k+1.
- A `tick` sampled at edge m while in RUN makes `pulse_out[i]`=1 during cycle m+1 (1-cycle latency).
- The last pulse and `done[i]` are high during the same cycle. `finished[i]` rises in that cycle and `busy[i]` falls in that cycle.
- Continuous `tick` with count N gives N consecutive `pulse_out` cycles, then stop.
- Zero-count start at edge k gives `done[i]` in cycle k+1 and `pulse_out` stays 0.
- Reset asserted mid-RUN clears all outputs immediately, asynchronously, and any in-flight pulse is lost. Release is synchronous to the next `clk` edge.

## Configuration
- Macro: `GATILHO_ABORT_EN`.
- When defined:
  - the `abort` input port exists;
  - `abort[i]`=1 in RUN moves the channel to IDLE on the next edge, clears `remaining`, issues no `pulse_out` and no `done`;
  - abort has priority over a simultaneous `tick`;
  - `abort` in IDLE or DONE is ignored;
  - `start[i]` and `abort[i]` high together in IDLE or DONE: the start wins.
- When undefined: no `abort` port and no abort logic; channels leave RUN only by completing the count or by reset.

## Test plan
- CHANNELS=4, COUNT_W=8, reset held low: all outputs 0.
  - Release reset, `start[0]`=1 with count 3, `tick` held 1.
  - Required: exactly 3 consecutive `pulse_out[0]`. `done[0]` coincides with the third pulse, then `finished[0]`=1 and `busy[0]`=0.
- Channel 1 count 2, `tick` every 4th cycle: `pulse_out[1]` one cycle after each of the first 2 ticks. Third and later ticks give no pulse.
- Start with count 0: `done` pulse next cycle, zero `pulse_out`, `finished`=1.
- Channels 0–3 started together with counts 1, 2, 3, 255 under continuous `tick`:
  - `done` pulses at cycles +1, +2, +3 and +255 after the first tick edge;
  - a re-start of channel 0 from DONE with count 4 yields 4 further pulses.
- Mid-RUN (channel 2 count 10, after 5 pulses):
  - drive `start[2]` with count 99: ignored, and 10 total pulses result;
  - repeat, asserting `reset`=0 after 5 pulses: outputs 0 immediately and no further pulses after release.
- `GATILHO_ABORT_EN` defined: channel 3 count 10, `abort[3]` and `tick` together after 4 pulses gives no 5th pulse, no `done`, and `busy[3]`=0 the next cycle.
